// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control sequencer for the simple RV64 core.
//
// Steps each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB and
// is the only source of datapath write strobes. It handshakes with the
// instruction and data memories and latches the opcode on the fetch ack.
//
// Build option:
//   MC_CTRL_ILLEGAL_TRAP_EN  defined   : an illegal opcode parks the FSM in
//                                        TRAP (left only by reset) and sets
//                                        the sticky illegal_o flag.
//                            undefined : an illegal opcode retires as a NOP
//                                        and illegal_o is tied to 0.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   imem_req_o/ack_i      instruction fetch handshake
//   imem_opcode_i[6:0]    instruction[6:0], sampled on the fetch ack
//   dmem_req_o/we_o/ack_i data access handshake (we: 1 = store)
//   zero_i                ALU zero flag, used by BEQ in EXEC
//   ir_we_o               instruction register load strobe
//   imm_sel_o[1:0]        immediate format: 00 I, 01 S, 11 B
//   alu_src_o             1 = immediate operand, 0 = rs2
//   pc_we_o, pc_sel_o     PC write strobe, 1 = PC+imm / 0 = PC+4
//   reg_we_o, wb_sel_o    register write strobe, 1 = load data / 0 = ALU
//   retire_o              one-cycle pulse per completed instruction
//   instret_o[CNT_W-1:0]  retired-instruction count (wraps)
//   illegal_o             sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    input  logic [6:0]       imem_opcode_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_ack_i,
    input  logic             zero_i,
    output logic             ir_we_o,
    output logic [1:0]       imm_sel_o,
    output logic             alu_src_o,
    output logic             pc_we_o,
    output logic             pc_sel_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o
);

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t          state;
    logic [6:0]      opcode;
    logic [CNT_W-1:0] instret;

    logic is_ld, is_sd, is_alui, is_r, is_beq, is_illegal;
    logic [1:0] imm_fmt;
    logic       use_imm;

    // Opcode class decode from the latched opcode.
    always_comb begin
        is_ld      = (opcode == OP_LD);
        is_sd      = (opcode == OP_SD);
        is_alui    = (opcode == OP_ALUI);
        is_r       = (opcode == OP_R);
        is_beq     = (opcode == OP_BEQ);
        is_illegal = !(is_ld || is_sd || is_alui || is_r || is_beq);
        imm_fmt    = is_beq ? 2'b11 : (is_sd ? 2'b01 : 2'b00);
        use_imm    = is_ld || is_sd || is_alui;
    end

    // Output decode. Everything is a function of the registered state and
    // opcode, except the strobes qualified by a same-cycle memory ack and
    // pc_sel_o, which must follow zero_i in the very cycle BEQ writes the PC.
    // Gating with rst_n holds every output low while reset is asserted, so
    // imem_req_o first rises in the cycle after release and strobes drop
    // the instant reset is applied.
    always_comb begin
        // NOTE: every output gets a default before the case so that no
        // state/branch combination leaves one unassigned and infers a latch.
        imem_req_o = 1'b0;
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        ir_we_o    = 1'b0;
        imm_sel_o  = 2'b00;
        alu_src_o  = 1'b0;
        pc_we_o    = 1'b0;
        pc_sel_o   = 1'b0;
        reg_we_o   = 1'b0;
        wb_sel_o   = 1'b0;
        retire_o   = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ack_i;
                end
                S_DECODE: begin
                    imm_sel_o = imm_fmt;
                end
                S_EXEC: begin
                    imm_sel_o = imm_fmt;
                    alu_src_o = use_imm;
                    if (is_beq) begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = zero_i;
                        retire_o = 1'b1;
                    end
                end
                S_MEM: begin
                    imm_sel_o  = imm_fmt;
                    alu_src_o  = use_imm;
                    dmem_req_o = 1'b1;
                    dmem_we_o  = is_sd;
                    if (is_sd && dmem_ack_i) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end
                end
                S_WB: begin
                    imm_sel_o = imm_fmt;
                    alu_src_o = use_imm;
                    // An illegal opcode only reaches WB as a NOP.
                    reg_we_o  = !is_illegal;
                    pc_we_o   = 1'b1;
                    wb_sel_o  = is_ld;
                    retire_o  = 1'b1;
                end
                default: ;  // S_TRAP: everything stays quiet.
            endcase
        end
    end

    // Sequencer state, opcode latch and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            opcode  <= 7'd0;
            instret <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            if (retire_o) instret <= instret + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        opcode <= imem_opcode_i;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state <= is_illegal ? S_TRAP : S_EXEC;
`else
                    state <= is_illegal ? S_WB : S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (is_beq)             state <= S_FETCH;
                    else if (is_ld || is_sd) state <= S_MEM;
                    else                     state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack_i) state <= is_sd ? S_FETCH : S_WB;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign instret_o = instret;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              illegal_q <= 1'b0;
        else if (state == S_DECODE && is_illegal) illegal_q <= 1'b1;
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl -- directed self-checking bench for mc_ctrl (CNT_W = 4 so the
// retire counter wrap is reachable). Inputs are driven just after the
// falling edge and outputs sampled 1 ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req_o, imem_ack_i;
    logic [6:0] imem_opcode_i;
    logic       dmem_req_o, dmem_we_o, dmem_ack_i;
    logic       zero_i;
    logic       ir_we_o;
    logic [1:0] imm_sel_o;
    logic       alu_src_o, pc_we_o, pc_sel_o, reg_we_o, wb_sel_o, retire_o;
    logic [3:0] instret_o;
    logic       illegal_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_cnt;

    // Observations of the most recent run_instr.
    int         obs_cycles, obs_ir_cycle, obs_dreq, obs_dwe, obs_regwe;
    logic [1:0] obs_imm;
    logic       obs_alu, obs_pcwe, obs_pcsel, obs_wbsel, obs_regwe_ret;
    logic [3:0] obs_instret;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_ack_i    (imem_ack_i),
        .imem_opcode_i (imem_opcode_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_ack_i    (dmem_ack_i),
        .zero_i        (zero_i),
        .ir_we_o       (ir_we_o),
        .imm_sel_o     (imm_sel_o),
        .alu_src_o     (alu_src_o),
        .pc_we_o       (pc_we_o),
        .pc_sel_o      (pc_sel_o),
        .reg_we_o      (reg_we_o),
        .wb_sel_o      (wb_sel_o),
        .retire_o      (retire_o),
        .instret_o     (instret_o),
        .illegal_o     (illegal_o)
    );

    // Drives one instruction from FETCH to retire with iw fetch wait cycles
    // and dw data wait cycles, recording what it sees. Bounded at 40 cycles;
    // a timeout leaves obs_cycles at 0.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                             input logic z);
        int  fcnt = 0;
        int  dcnt = 0;
        bit  done = 0;
        obs_cycles = 0; obs_ir_cycle = 0; obs_dreq = 0; obs_dwe = 0;
        obs_regwe = 0;
        obs_imm = 2'bxx; obs_alu = 1'bx; obs_pcwe = 1'bx; obs_pcsel = 1'bx;
        obs_wbsel = 1'bx; obs_regwe_ret = 1'bx;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            imem_opcode_i = op;
            zero_i        = z;
            imem_ack_i    = imem_req_o && (fcnt == iw);
            if (imem_req_o) fcnt++;
            dmem_ack_i    = dmem_req_o && (dcnt == dw);
            if (dmem_req_o) dcnt++;
            #1;
            if (ir_we_o) obs_ir_cycle = c;
            if (dmem_req_o) begin
                obs_dreq++;
                if (dmem_we_o) obs_dwe++;
            end
            if (reg_we_o) obs_regwe++;
            if (retire_o) begin
                done          = 1;
                obs_cycles    = c;
                obs_imm       = imm_sel_o;
                obs_alu       = alu_src_o;
                obs_pcwe      = pc_we_o;
                obs_pcsel     = pc_sel_o;
                obs_wbsel     = wb_sel_o;
                obs_regwe_ret = reg_we_o;
            end
        end
        @(posedge clk);
        #1;
        imem_ack_i  = 1'b0;
        dmem_ack_i  = 1'b0;
        obs_instret = instret_o;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imem_ack_i = 1'b1; imem_opcode_i = OP_R;
        dmem_ack_i = 1'b0; zero_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b expected 0", imem_req_o); end
        checks++; if ({ir_we_o, pc_we_o, reg_we_o, retire_o, dmem_req_o} !== 5'b0) begin errors++; $display("FAIL rst_strobes: got %b expected 00000", {ir_we_o, pc_we_o, reg_we_o, retire_o, dmem_req_o}); end
        checks++; if ({imm_sel_o, alu_src_o, pc_sel_o, wb_sel_o} !== 5'b0) begin errors++; $display("FAIL rst_selects: got %b expected 00000", {imm_sel_o, alu_src_o, pc_sel_o, wb_sel_o}); end
        checks++; if (instret_o !== 4'd0 || illegal_o !== 1'b0) begin errors++; $display("FAIL rst_counters: got instret=%0d illegal=%b expected 0/0", instret_o, illegal_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Cycle 1 after release: fetch, ack tied high.
        checks++; if ({imem_req_o, ir_we_o} !== 2'b11) begin errors++; $display("FAIL c1_fetch: got req/ir_we=%b expected 11", {imem_req_o, ir_we_o}); end
        @(negedge clk); #1;
        imem_ack_i = 1'b0;
        checks++; if (ir_we_o !== 1'b0) begin errors++; $display("FAIL c2_ir_we: got %b expected 0", ir_we_o); end
        @(negedge clk); #1;
        checks++; if (alu_src_o !== 1'b0 || retire_o !== 1'b0) begin errors++; $display("FAIL c3_exec: got alu_src=%b retire=%b expected 0/0", alu_src_o, retire_o); end
        @(negedge clk); #1;
        checks++; if ({reg_we_o, retire_o, pc_we_o, pc_sel_o, wb_sel_o} !== 5'b11100) begin errors++; $display("FAIL c4_wb: got %b expected 11100", {reg_we_o, retire_o, pc_we_o, pc_sel_o, wb_sel_o}); end
        @(posedge clk); #1;
        exp_cnt = 4'd1;
        checks++; if (instret_o !== exp_cnt) begin errors++; $display("FAIL rtype_instret: got %0d expected %0d", instret_o, exp_cnt); end
    endtask

    task automatic test_load_wait;
        run_instr(OP_LD, 0, 3, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 8) begin errors++; $display("FAIL ld_cycles: got %0d expected 8", obs_cycles); end
        checks++; if (obs_dreq !== 4 || obs_dwe !== 0) begin errors++; $display("FAIL ld_dreq: got req=%0d we=%0d expected 4/0", obs_dreq, obs_dwe); end
        checks++; if ({obs_regwe_ret, obs_wbsel, obs_pcwe, obs_pcsel} !== 4'b1110) begin errors++; $display("FAIL ld_wb: got %b expected 1110", {obs_regwe_ret, obs_wbsel, obs_pcwe, obs_pcsel}); end
        checks++; if (obs_imm !== 2'b00 || obs_alu !== 1'b1) begin errors++; $display("FAIL ld_sel: got imm=%b alu=%b expected 00/1", obs_imm, obs_alu); end
        checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL ld_instret: got %0d expected %0d", obs_instret, exp_cnt); end
    endtask

    task automatic test_store;
        run_instr(OP_SD, 0, 0, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 4) begin errors++; $display("FAIL sd_cycles: got %0d expected 4", obs_cycles); end
        checks++; if (obs_imm !== 2'b01 || obs_alu !== 1'b1) begin errors++; $display("FAIL sd_sel: got imm=%b alu=%b expected 01/1", obs_imm, obs_alu); end
        checks++; if (obs_dreq !== 1 || obs_dwe !== 1) begin errors++; $display("FAIL sd_dmem: got req=%0d we=%0d expected 1/1", obs_dreq, obs_dwe); end
        checks++; if (obs_regwe !== 0 || obs_pcwe !== 1'b1) begin errors++; $display("FAIL sd_strobes: got reg_we_cycles=%0d pc_we=%b expected 0/1", obs_regwe, obs_pcwe); end
        checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL sd_instret: got %0d expected %0d", obs_instret, exp_cnt); end
    endtask

    task automatic test_branch;
        run_instr(OP_BEQ, 0, 0, 1'b1);
        exp_cnt++;
        checks++; if (obs_cycles !== 3 || obs_pcsel !== 1'b1 || obs_pcwe !== 1'b1) begin errors++; $display("FAIL beq_taken: got cycles=%0d pc_sel=%b pc_we=%b expected 3/1/1", obs_cycles, obs_pcsel, obs_pcwe); end
        checks++; if (obs_imm !== 2'b11 || obs_alu !== 1'b0 || obs_regwe !== 0) begin errors++; $display("FAIL beq_sel: got imm=%b alu=%b reg_we=%0d expected 11/0/0", obs_imm, obs_alu, obs_regwe); end
        run_instr(OP_BEQ, 0, 0, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 3 || obs_pcsel !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got cycles=%0d pc_sel=%b expected 3/0", obs_cycles, obs_pcsel); end
        checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL beq_instret: got %0d expected %0d", obs_instret, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        // Two fetch wait cycles on an ALU-immediate op.
        run_instr(OP_ALUI, 2, 0, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 6 || obs_ir_cycle !== 3) begin errors++; $display("FAIL alui_wait: got cycles=%0d ir_we_cycle=%0d expected 6/3", obs_cycles, obs_ir_cycle); end
        checks++; if (obs_alu !== 1'b1 || obs_imm !== 2'b00 || obs_wbsel !== 1'b0) begin errors++; $display("FAIL alui_sel: got alu=%b imm=%b wb_sel=%b expected 1/00/0", obs_alu, obs_imm, obs_wbsel); end
        // One wait on each memory for a load.
        run_instr(OP_LD, 1, 1, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 7 || obs_dreq !== 2) begin errors++; $display("FAIL ld_both_wait: got cycles=%0d dreq=%0d expected 7/2", obs_cycles, obs_dreq); end
        checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL b2b_instret: got %0d expected %0d", obs_instret, exp_cnt); end
    endtask

    task automatic test_reset_abort;
        bit seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            imem_opcode_i = OP_LD;
            imem_ack_i    = imem_req_o;
            dmem_ack_i    = 1'b0;
            #1;
            if (dmem_req_o) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_reach_mem: got no dmem_req_o expected 1 within 10 cycles"); end
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 4'd0;
        checks++; if (dmem_req_o !== 1'b0 || retire_o !== 1'b0) begin errors++; $display("FAIL abort_dreq: got req=%b retire=%b expected 0/0", dmem_req_o, retire_o); end
        checks++; if (instret_o !== exp_cnt) begin errors++; $display("FAIL abort_instret: got %0d expected 0", instret_o); end
        imem_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL abort_refetch: got %b expected 1", imem_req_o); end
        run_instr(OP_R, 0, 0, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 4 || obs_instret !== exp_cnt) begin errors++; $display("FAIL abort_next: got cycles=%0d instret=%0d expected 4/%0d", obs_cycles, obs_instret, exp_cnt); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        for (int i = 0; i < 16; i++) begin
            run_instr(OP_ALUI, 0, 0, 1'b0);
            exp_cnt++;
            checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL wrap_instret_%0d: got %0d expected %0d", i, obs_instret, exp_cnt); end
        end
    endtask

    task automatic test_illegal;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        int reqs = 0;
        int strobes = 0;
        @(negedge clk);
        imem_opcode_i = OP_BAD;
        imem_ack_i    = imem_req_o;
        @(posedge clk); #1;
        imem_ack_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            imem_ack_i = 1'b1;
            dmem_ack_i = 1'b1;
            #1;
            if (imem_req_o || dmem_req_o) reqs++;
            if (ir_we_o || pc_we_o || reg_we_o || retire_o) strobes++;
        end
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL trap_flag: got %b expected 1", illegal_o); end
        checks++; if (reqs !== 0 || strobes !== 0) begin errors++; $display("FAIL trap_quiet: got req_cycles=%0d strobe_cycles=%0d expected 0/0", reqs, strobes); end
        checks++; if (instret_o !== exp_cnt) begin errors++; $display("FAIL trap_instret: got %0d expected %0d", instret_o, exp_cnt); end
`else
        run_instr(OP_BAD, 0, 0, 1'b0);
        exp_cnt++;
        checks++; if (obs_cycles !== 3 || obs_regwe !== 0) begin errors++; $display("FAIL nop_retire: got cycles=%0d reg_we_cycles=%0d expected 3/0", obs_cycles, obs_regwe); end
        checks++; if (obs_pcwe !== 1'b1 || obs_pcsel !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL nop_pc: got pc_we=%b pc_sel=%b illegal=%b expected 1/0/0", obs_pcwe, obs_pcsel, illegal_o); end
        checks++; if (obs_instret !== exp_cnt) begin errors++; $display("FAIL nop_instret: got %0d expected %0d", obs_instret, exp_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_store();
        test_branch();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
